entropy_pool: RTL and testbench

Parametrised successor to the single-source randomized LFSR byte path. Accepts N raw metastable/ring-oscillator bits, synchronises and XOR-combines them, and optionally von-Neumann debiases the result. Mixes accepted bits into a configurable LFSR and emits one byte per BITS_PER_BYTE accepted bits into a FIFO. Adds a stuck-source health monitor. Sits between the entropy sources and the UART transmitter, which drains it via a valid/ready byte stream.

---
 rtl/entropy_pool_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 78 +++++++
 rtl/entropy_pool.sv | 186 ++++++++++++++++++
 tb/tb_entropy_pool.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/entropy_pool_pkg.sv
// Shared types and helpers for the entropy pool and its FIFO.
package entropy_pool_pkg;

  // Default feedback tap masks for the common mixing LFSR widths
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  // Von Neumann debias pairing state
  typedef enum logic {
    DB_IDLE  = 1'b0,
    DB_FIRST = 1'b1
  } debias_state_t;

  // Bits needed to hold an occupancy of 0..depth
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Bits needed for a counter running 0..limit-1 (never narrower than 1)
  function automatic int unsigned count_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty/level.
module sync_fifo
  import entropy_pool_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [level_width(DEPTH)-1:0]  level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = level_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [LW-1:0]    level_next;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside a pop
  always_comb begin
    do_pop     = pop && !empty;
    do_push    = push && (!full || do_pop);
    level_next = level;
    if (do_push && !do_pop) begin
      level_next = level + LW'(1);
    end else if (!do_push && do_pop) begin
      level_next = level - LW'(1);
    end
  end

  // Pointers and status flags; clear empties the FIFO regardless of push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_next;
      empty <= (level_next == '0);
      full  <= (level_next == LW'(DEPTH));
    end
  end

  // Storage array, no reset needed since reads are qualified by empty
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/entropy_pool.sv
// Multi-source entropy collector: sync, XOR-combine, optional debias, LFSR mix, byte FIFO.
module entropy_pool
  import entropy_pool_pkg::*;
#(
  parameter int unsigned           N_CHANNELS    = 4,
  parameter int unsigned           LFSR_WIDTH    = 16,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS     = LFSR_TAPS_16,
  parameter int unsigned           BITS_PER_BYTE = 16,
  parameter int unsigned           FIFO_DEPTH    = 16,
  parameter bit                    DEBIAS        = 1'b1,
  parameter int unsigned           STUCK_LIMIT   = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_CHANNELS-1:0]         entropy_in,
  input  logic [N_CHANNELS-1:0]         channel_enable,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_byte,
  output logic                          bit_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   overflow_count,
  output logic                          health_fail
);

  localparam int unsigned LEVEL_W = level_width(FIFO_DEPTH);
  localparam int unsigned CNT_W   = count_width(BITS_PER_BYTE);
  localparam int unsigned RUN_W   = $clog2(STUCK_LIMIT + 1);

  logic [N_CHANNELS-1:0] sync_meta;
  logic [N_CHANNELS-1:0] sync_q;
  logic                  combined;
  logic                  raw_accept;
  logic                  accept_bit;
  logic                  accept;
  logic [LFSR_WIDTH-1:0] lfsr;
  logic [LFSR_WIDTH-1:0] lfsr_next;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  byte_done;
  logic                  push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [LEVEL_W-1:0]    level;
  logic                  drop;
  logic [RUN_W-1:0]      run_len;
  logic [RUN_W-1:0]      run_next;
  logic                  last_combined;

  // Two-flop synchroniser per raw entropy channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= entropy_in;
      sync_q    <= sync_meta;
    end
  end

  assign combined = ^(sync_q & channel_enable);

  generate
    if (DEBIAS) begin : g_debias
      debias_state_t db_state;
      logic          db_first_bit;

      // Von Neumann pairing: store first bit, emit it only if the second differs
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          db_state     <= DB_IDLE;
          db_first_bit <= 1'b0;
        end else if (flush) begin
          db_state     <= DB_IDLE;
          db_first_bit <= 1'b0;
        end else begin
          case (db_state)
            DB_IDLE: begin
              db_first_bit <= combined;
              db_state     <= DB_FIRST;
            end
            DB_FIRST: db_state <= DB_IDLE;
            default:  db_state <= DB_IDLE;
          endcase
        end
      end

      assign raw_accept = (db_state == DB_FIRST) && (combined != db_first_bit);
      assign accept_bit = db_first_bit;
    end else begin : g_raw
      assign raw_accept = 1'b1;
      assign accept_bit = combined;
    end
  endgenerate

  // Flush cycles mix nothing so the LFSR value survives a flush untouched
  assign accept    = raw_accept && !flush;
  assign lfsr_next = {lfsr[LFSR_WIDTH-2:0], (^(lfsr & LFSR_TAPS)) ^ accept_bit};
  assign byte_done = accept && (bit_cnt == CNT_W'(BITS_PER_BYTE - 1));
  assign push      = byte_done && !health_fail;
  assign drop      = push && fifo_full && !out_ready;

  // Mixing LFSR and the one-cycle accepted-bit strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= LFSR_WIDTH'(1);
      bit_ready <= 1'b0;
    end else begin
      if (accept) begin
        lfsr <= lfsr_next;
      end
      bit_ready <= accept;
    end
  end

  // Accepted-bit counter, wraps when a byte is requested
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (flush) begin
      bit_cnt <= '0;
    end else if (accept) begin
      bit_cnt <= byte_done ? '0 : bit_cnt + CNT_W'(1);
    end
  end

  // Saturating count of bytes lost to a full FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_count <= '0;
    end else if (flush) begin
      overflow_count <= '0;
    end else if (drop && (overflow_count != 16'hFFFF)) begin
      overflow_count <= overflow_count + 16'd1;
    end
  end

  // Next run length of identical combined samples; zero means no previous sample
  always_comb begin
    run_next = run_len;
    if ((run_len == '0) || (combined != last_combined)) begin
      run_next = RUN_W'(1);
    end else if (run_len != RUN_W'(STUCK_LIMIT)) begin
      run_next = run_len + RUN_W'(1);
    end
  end

  // Stuck-source monitor with sticky failure flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_len       <= '0;
      last_combined <= 1'b0;
      health_fail   <= 1'b0;
    end else if (flush) begin
      run_len       <= '0;
      last_combined <= 1'b0;
      health_fail   <= 1'b0;
    end else begin
      run_len       <= run_next;
      last_combined <= combined;
      if (run_next == RUN_W'(STUCK_LIMIT)) begin
        health_fail <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (push),
    .pop   (out_ready),
    .wdata (lfsr_next[7:0]),
    .rdata (out_byte),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign out_valid  = !fifo_empty;
  assign fifo_level = level;

endmodule

// File: tb/tb_entropy_pool.sv
// Directed bench: raw (no debias, 8 bits/byte) and debiased (3 bits/byte) instances.
module tb_entropy_pool;

  logic clk;
  logic rst_n;

  logic [3:0] ent_raw, en_raw, ent_vn, en_vn;
  logic       flush_raw, ready_raw, flush_vn, ready_vn;
  logic       valid_raw, br_raw, hf_raw, valid_vn, br_vn, hf_vn;
  logic [7:0] byte_raw, byte_vn;
  logic [4:0] lvl_raw, lvl_vn;
  logic [15:0] ovf_raw, ovf_vn;

  entropy_pool #(
    .N_CHANNELS(4), .LFSR_WIDTH(16), .LFSR_TAPS(16'hB400), .BITS_PER_BYTE(8),
    .FIFO_DEPTH(16), .DEBIAS(1'b0), .STUCK_LIMIT(64)
  ) u_raw (
    .clk(clk), .rst_n(rst_n), .entropy_in(ent_raw), .channel_enable(en_raw),
    .flush(flush_raw), .out_valid(valid_raw), .out_ready(ready_raw),
    .out_byte(byte_raw), .bit_ready(br_raw), .fifo_level(lvl_raw),
    .overflow_count(ovf_raw), .health_fail(hf_raw)
  );

  entropy_pool #(
    .N_CHANNELS(4), .LFSR_WIDTH(16), .LFSR_TAPS(16'hB400), .BITS_PER_BYTE(3),
    .FIFO_DEPTH(16), .DEBIAS(1'b1), .STUCK_LIMIT(64)
  ) u_vn (
    .clk(clk), .rst_n(rst_n), .entropy_in(ent_vn), .channel_enable(en_vn),
    .flush(flush_vn), .out_valid(valid_vn), .out_ready(ready_vn),
    .out_byte(byte_vn), .bit_ready(br_vn), .fifo_level(lvl_vn),
    .overflow_count(ovf_vn), .health_fail(hf_vn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int pat_idx = 0;

  // Reference LFSR for the raw instance: every non-flush cycle mixes the combined bit
  logic [3:0]  m_s1, m_s2;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s, input logic b);
    return {s[14:0], (^(s & 16'hB400)) ^ b};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1   <= 4'h0;
      m_s2   <= 4'h0;
      m_lfsr <= 16'h0001;
    end else begin
      m_s1 <= ent_raw;
      m_s2 <= m_s1;
      if (!flush_raw) m_lfsr <= lfsr_step(m_lfsr, ^(m_s2 & en_raw));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Run n raw cycles; pattern=0 toggles channel 0, pattern=1 drives a multi-channel sequence
  task automatic run_raw(input int n, input bit pattern);
    for (int k = 0; k < n; k++) begin
      ent_raw = pattern ? 4'(pat_idx * 5 + 3) : {3'b000, pat_idx[0]};
      pat_idx++;
      tick();
    end
  endtask

  task automatic flush_raw_cycle();
    flush_raw = 1'b1;
    tick();
    flush_raw = 1'b0;
  endtask

  typedef struct packed {
    logic       vn_e;
    logic       vn_br;
    logic       vn_valid;
    logic [7:0] vn_byte;
    logic       raw_br;
    logic [4:0] raw_level;
    logic [7:0] raw_byte;
  } row_t;

  row_t tbl [16];

  initial begin
    // Debias pairs from P2: 01,10,00,11,01 -> accepts 0,1,0 at rows 3,5,11 -> byte 0x0A.
    // Raw: constant zero, byte 0x00 after 8 cycles, second byte at row 15.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 8'h00};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 8'h00};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 8'h00};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 8'h00};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 8'h00};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 8'h00};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 8'h00};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 8'h00};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 8'h00};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 8'h0A, 1'b1, 5'd1, 8'h00};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 8'h0A, 1'b1, 5'd1, 8'h00};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 8'h0A, 1'b1, 5'd1, 8'h00};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 8'h0A, 1'b1, 5'd1, 8'h00};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 8'h0A, 1'b1, 5'd2, 8'h00};

    rst_n     = 1'b0;
    ent_raw   = 4'h0; en_raw = 4'b0001; flush_raw = 1'b0; ready_raw = 1'b0;
    ent_vn    = 4'h0; en_vn  = 4'b0001; flush_vn  = 1'b0; ready_vn  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state of both instances
    check("rst_raw_valid", valid_raw, 0);
    check("rst_raw_level", lvl_raw, 0);
    check("rst_raw_bit_ready", br_raw, 0);
    check("rst_raw_overflow", ovf_raw, 0);
    check("rst_raw_health", hf_raw, 0);
    check("rst_vn_valid", valid_vn, 0);
    check("rst_vn_level", lvl_vn, 0);
    check("rst_vn_bit_ready", br_vn, 0);
    check("rst_vn_overflow", ovf_vn, 0);
    check("rst_vn_health", hf_vn, 0);

    // Tests 1 and 2 run side by side from reset release
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ent_vn = {3'b000, tbl[i].vn_e};
      tick();
      check($sformatf("t2_vn_bit_ready[%0d]", i), br_vn, tbl[i].vn_br);
      check($sformatf("t2_vn_valid[%0d]", i), valid_vn, tbl[i].vn_valid);
      if (tbl[i].vn_valid) check($sformatf("t2_vn_byte[%0d]", i), byte_vn, tbl[i].vn_byte);
      check($sformatf("t1_raw_bit_ready[%0d]", i), br_raw, tbl[i].raw_br);
      check($sformatf("t1_raw_level[%0d]", i), lvl_raw, tbl[i].raw_level);
      check($sformatf("t1_raw_valid[%0d]", i), valid_raw, tbl[i].raw_level != 0);
      if (tbl[i].raw_level != 0) check($sformatf("t1_raw_byte[%0d]", i), byte_raw, tbl[i].raw_byte);
    end

    // Test 3: fill past capacity with out_ready low
    flush_raw_cycle();
    check("t3_flush_level", lvl_raw, 0);
    run_raw(159, 1'b0);
    check("t3_level_19_bytes", lvl_raw, 16);
    check("t3_overflow_19_bytes", ovf_raw, 3);
    run_raw(1, 1'b0);
    check("t3_level_20_bytes", lvl_raw, 16);
    check("t3_overflow_20_bytes", ovf_raw, 4);
    run_raw(7, 1'b0);
    check("t3_overflow_hold", ovf_raw, 4);
    ready_raw = 1'b1;
    run_raw(1, 1'b0);
    ready_raw = 1'b0;
    check("t3_pushpop_full_level", lvl_raw, 16);
    check("t3_pushpop_full_overflow", ovf_raw, 4);
    check("t3_health", hf_raw, 0);

    // Test 4: all channels disabled -> stuck combined value
    en_raw = 4'b0000;
    flush_raw_cycle();
    check("t4_flush_overflow", ovf_raw, 0);
    run_raw(63, 1'b0);
    check("t4_health_63", hf_raw, 0);
    check("t4_level_63", lvl_raw, 7);
    run_raw(1, 1'b0);
    check("t4_health_64", hf_raw, 1);
    check("t4_level_64", lvl_raw, 8);
    run_raw(16, 1'b0);
    check("t4_no_push_level", lvl_raw, 8);
    check("t4_no_push_overflow", ovf_raw, 0);
    check("t4_health_sticky", hf_raw, 1);
    flush_raw_cycle();
    check("t4_flush_health", hf_raw, 0);
    check("t4_flush_level", lvl_raw, 0);
    check("t4_flush_valid", valid_raw, 0);

    // Test 5: flush coinciding with push and pop at level 5
    en_raw = 4'b1011;
    run_raw(47, 1'b1);
    check("t5_level_before", lvl_raw, 5);
    flush_raw = 1'b1;
    ready_raw = 1'b1;
    run_raw(1, 1'b1);
    flush_raw = 1'b0;
    ready_raw = 1'b0;
    check("t5_flush_level", lvl_raw, 0);
    check("t5_flush_valid", valid_raw, 0);
    run_raw(7, 1'b1);
    check("t5_level_7_bits", lvl_raw, 0);
    run_raw(1, 1'b1);
    check("t5_level_8_bits", lvl_raw, 1);
    check("t5_lfsr_preserved_byte", byte_raw, m_lfsr[7:0]);

    // Test 6: reset mid-byte with level 3 and counter 5
    run_raw(21, 1'b1);
    check("t6_level_before", lvl_raw, 3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", valid_raw, 0);
    check("t6_rst_level", lvl_raw, 0);
    check("t6_rst_bit_ready", br_raw, 0);
    check("t6_rst_overflow", ovf_raw, 0);
    check("t6_rst_health", hf_raw, 0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    run_raw(7, 1'b1);
    check("t6_level_7_bits", lvl_raw, 0);
    run_raw(1, 1'b1);
    check("t6_level_8_bits", lvl_raw, 1);
    check("t6_first_byte", byte_raw, m_lfsr[7:0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
